// File: rtl/crc8_frame_ctrl.sv
// crc8_frame_ctrl: CRC-8 (poly 0x07, MSB-first) frame checker with a result handshake and an error counter
// ports: clk/rst        clock, synchronous active-high reset
//        in_valid/in_ready/in_data/in_last   byte stream; the in_last byte carries the received CRC
//        abort          drops the frame in progress (ignored while a result is pending)
//        res_valid/res_ready/res_crc/res_ok/res_len   result, held until taken
//        err_cnt        saturating count of frames whose CRC did not match
module crc8_frame_ctrl #(
  parameter logic [7:0] INIT    = 8'h00,
  parameter logic [7:0] XOR_OUT = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  input  logic        abort,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [7:0]  res_crc,
  output logic        res_ok,
  output logic [15:0] res_len,
  output logic [7:0]  err_cnt
);
  typedef enum logic [1:0] {IDLE, ACC, RESULT} state_t;
  state_t      state_q, state_d;
  logic [7:0]  crc_q, crc_d, res_crc_q, res_crc_d, err_cnt_q, err_cnt_d, fin;
  logic [15:0] len_q, len_d, res_len_q, res_len_d;
  logic        res_ok_q, res_ok_d, acc;
  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? {r[6:0], 1'b0} ^ 8'h07 : {r[6:0], 1'b0};
    return r;
  endfunction
  assign in_ready  = state_q != RESULT;
  assign res_valid = state_q == RESULT;
  assign res_crc   = res_crc_q;
  assign res_ok    = res_ok_q;
  assign res_len   = res_len_q;
  assign err_cnt   = err_cnt_q;
  assign acc       = in_valid && in_ready;
  assign fin       = crc_q ^ XOR_OUT;
  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    len_d     = len_q;
    res_crc_d = res_crc_q;
    res_ok_d  = res_ok_q;
    res_len_d = res_len_q;
    err_cnt_d = err_cnt_q;
    if (state_q == RESULT) begin
      if (res_ready) begin
        state_d = IDLE;
        crc_d   = INIT;
        len_d   = '0;
      end
    end else if (abort) begin
      state_d = IDLE;
      crc_d   = INIT;
      len_d   = '0;
    end else if (acc && in_last) begin
      state_d   = RESULT;
      res_crc_d = fin;
      res_ok_d  = fin == in_data;
      res_len_d = len_q;
      err_cnt_d = (fin != in_data && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    end else if (acc) begin
      state_d = ACC;
      crc_d   = crc_step(crc_q, in_data);
      len_d   = len_q == 16'hFFFF ? len_q : len_q + 16'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      crc_q     <= INIT;
      len_q     <= '0;
      res_crc_q <= '0;
      res_ok_q  <= 1'b0;
      res_len_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      len_q     <= len_d;
      res_crc_q <= res_crc_d;
      res_ok_q  <= res_ok_d;
      res_len_q <= res_len_d;
      err_cnt_q <= err_cnt_d;
    end
  end
endmodule

// File: tb/tb_crc8_frame_ctrl.sv
// tb_crc8_frame_ctrl: directed and randomized checks of crc8_frame_ctrl against a polynomial-division model
module tb_crc8_frame_ctrl;
  logic        clk = 0, rst = 1, in_valid = 0, in_last = 0, abort = 0, res_ready = 0;
  logic [7:0]  in_data = 0;
  logic        in_ready, res_valid, res_ok;
  logic [7:0]  res_crc, err_cnt;
  logic [15:0] res_len;
  int checks = 0, errors = 0, err_exp = 0;
  logic [7:0] pl[$];
  crc8_frame_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .abort(abort), .res_valid(res_valid), .res_ready(res_ready),
    .res_crc(res_crc), .res_ok(res_ok), .res_len(res_len), .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  // remainder of M(x)*x^8 divided by x^8+x^2+x+1, one message bit at a time
  function automatic logic [7:0] ref_crc(input logic [7:0] m[$]);
    logic [8:0] r;
    int nb;
    logic b;
    r  = '0;
    nb = m.size() * 8;
    for (int i = 0; i < nb + 8; i++) begin
      b = (i < nb) ? m[i / 8][7 - (i % 8)] : 1'b0;
      r = {r[7:0], b};
      if (r[8]) r = r ^ 9'h107;
    end
    return r[7:0];
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic beat(input logic [7:0] d, input logic l);
    int n;
    @(negedge clk);
    in_valid = 1;
    in_data  = d;
    in_last  = l;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) chk("beat_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 0;
    in_last  = 0;
  endtask
  task automatic run_frame(input logic [7:0] p[$], input logic [7:0] lb, input string tag);
    logic [7:0] e;
    foreach (p[i]) beat(p[i], 1'b0);
    beat(lb, 1'b1);
    e = ref_crc(p);
    if (e != lb && err_exp < 255) err_exp++;
    chk({tag, "_valid"}, res_valid, 1);
    chk({tag, "_crc"}, res_crc, e);
    chk({tag, "_ok"}, res_ok, e == lb);
    chk({tag, "_len"}, res_len, p.size());
    chk({tag, "_err"}, err_cnt, err_exp);
  endtask
  task automatic take();
    @(negedge clk);
    res_ready = 1;
    @(posedge clk);
    #1;
    res_ready = 0;
    chk("take_idle_ready", in_ready, 1);
    chk("take_valid_low", res_valid, 0);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    chk("rst_valid", res_valid, 0);
    chk("rst_crc", res_crc, 0);
    chk("rst_ok", res_ok, 0);
    chk("rst_len", res_len, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_ready", in_ready, 1);
    pl = '{8'h01};
    run_frame(pl, 8'h07, "basic");
    chk("basic_crc_const", res_crc, 8'h07);
    take();
    pl = {};
    for (int i = 0; i < 9; i++) pl.push_back(8'h31 + 8'(i));
    run_frame(pl, 8'hF4, "check");
    chk("check_crc_const", res_crc, 8'hF4);
    chk("check_err_const", err_cnt, 0);
    take();
    run_frame(pl, 8'hF5, "bad");
    chk("bad_err_const", err_cnt, 1);
    take();
    for (int k = 0; k < 300; k++) begin
      foreach (pl[i]) beat(pl[i], 1'b0);
      beat(8'hF5, 1'b1);
      if (err_exp < 255) err_exp++;
      take();
    end
    chk("sat_err", err_cnt, err_exp);
    chk("sat_err_const", err_cnt, 8'hFF);
    run_frame(pl, 8'hF5, "sat_more");
    chk("sat_more_const", err_cnt, 8'hFF);
    take();
    // hold a last beat (empty frame, crc byte 00) while a result is pending
    run_frame(pl, 8'hF4, "stall");
    @(negedge clk);
    in_valid = 1;
    in_data  = 8'h00;
    in_last  = 1;
    abort    = 1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("stall_valid", res_valid, 1);
      chk("stall_crc", res_crc, 8'hF4);
      chk("stall_ok", res_ok, 1);
      chk("stall_len", res_len, 9);
      chk("stall_ready", in_ready, 0);
    end
    @(negedge clk);
    abort     = 0;
    res_ready = 1;
    @(posedge clk);
    #1;
    res_ready = 0;
    chk("stall_released_valid", res_valid, 0);
    chk("stall_released_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 0;
    in_last  = 0;
    chk("empty_valid", res_valid, 1);
    chk("empty_crc", res_crc, 8'h00);
    chk("empty_ok", res_ok, 1);
    chk("empty_len", res_len, 0);
    take();
    beat(8'h11, 1'b0);
    beat(8'h22, 1'b0);
    beat(8'h33, 1'b0);
    @(negedge clk);
    abort = 1;
    @(posedge clk);
    #1;
    abort = 0;
    chk("abort_valid", res_valid, 0);
    chk("abort_ready", in_ready, 1);
    pl = '{8'h00};
    run_frame(pl, 8'h00, "post_abort");
    chk("post_abort_len_const", res_len, 1);
    take();
    beat(8'hAA, 1'b0);
    @(negedge clk);
    in_valid = 1;
    in_data  = 8'h55;
    in_last  = 1;
    abort    = 1;
    @(posedge clk);
    #1;
    in_valid = 0;
    in_last  = 0;
    abort    = 0;
    chk("abort_last_valid", res_valid, 0);
    @(posedge clk);
    #1;
    chk("abort_last_valid2", res_valid, 0);
    chk("abort_last_err", err_cnt, err_exp);
    pl = '{8'h01};
    run_frame(pl, 8'h07, "post_abort_last");
    take();
    for (int i = 0; i < 4; i++) beat(8'(i * 37 + 5), 1'b0);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    rst     = 0;
    err_exp = 0;
    chk("midrst_valid", res_valid, 0);
    chk("midrst_crc", res_crc, 0);
    chk("midrst_ok", res_ok, 0);
    chk("midrst_len", res_len, 0);
    chk("midrst_err", err_cnt, 0);
    chk("midrst_ready", in_ready, 1);
    pl = '{8'h01};
    run_frame(pl, 8'h07, "post_rst");
    take();
    for (int f = 0; f < 40; f++) begin
      logic [7:0] lb;
      pl = {};
      repeat ($urandom_range(0, 12)) pl.push_back(8'($urandom));
      lb = $urandom_range(0, 1) ? ref_crc(pl) : 8'($urandom);
      run_frame(pl, lb, "rand");
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
        chk("rand_hold", res_valid, 1);
      end
      take();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
